audio_dac_serializer: RTL and testbench

Converts 32-bit parallel stereo sample words (left in [31:16], right in [15:0]) into the I2S serial stream for the codec DAC. It is the transmit end of the codec audio interface and sits between the moving-average filter output and the AUD_DACDAT pin. Codec-mastered AUD_BCLK and AUD_DACLRCK are oversampled in the system clock domain, and a one-deep holding buffer with a valid/ready handshake decouples the producer from frame timing.

---
 rtl/audio_dac_serializer_if.sv | 22 ++
 rtl/audio_dac_serializer.sv | 163 ++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_serializer_if.sv
// Sample handshake bundle between the filter (master) and the I2S DAC serializer (slave).
// A word moves on every rising clk edge where sample_valid && sample_ready are both high;
// the master holds sample_in stable while sample_valid is high, and sample_ready never depends on sample_valid.
interface audio_dac_serializer_if #(
    parameter int SAMPLE_W = 16
) ();
    logic [2*SAMPLE_W-1:0] sample_in;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer: one-deep sample buffer feeding a frame register shifted out on codec BCLK falls.
// Define DAC_HOLD_LAST_EN to repeat the previous frame on underrun instead of sending silence.
module audio_dac_serializer #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         AUD_BCLK,
    input  logic                         AUD_DACLRCK,
    audio_dac_serializer_if.slave        s_if,
    output logic                         AUD_DACDAT,
    output logic                         frame_done,
    output logic                         underrun,
    output logic [1:0]                   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int SLOT_W  = $clog2(SAMPLE_W + 2);
    localparam logic [SLOT_W-1:0] SLOT_MAX       = SLOT_W'(SAMPLE_W + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST_DATA = SLOT_W'(SAMPLE_W);

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic                   bclk_dly_q, bclk_dly_d;
    logic                   bclk_s, lrck_s, bclk_fall;

    state_e                 state_q, state_d;
    logic                   lrck_prev_q, lrck_prev_d;
    logic                   chan_q, chan_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [FRAME_W-1:0]     buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   ready_q, ready_d;
    logic                   dacdat_q, dacdat_d;

    logic                   load, lrck_edge, left_start, accept, slot_has_data;
    logic [SAMPLE_W-1:0]    half_sel, half_shift;

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign bclk_fall = bclk_dly_q & ~bclk_s;

    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
        lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], AUD_DACLRCK};
        bclk_dly_d  = bclk_s;
    end

    always_comb begin
        state_d     = state_q;
        lrck_prev_d = lrck_prev_q;
        chan_d      = chan_q;
        slot_d      = slot_q;
        frame_d     = frame_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        dacdat_d    = dacdat_q;
        frame_done  = 1'b0;
        underrun    = 1'b0;
        load        = 1'b0;
        lrck_edge   = lrck_s ^ lrck_prev_q;
        left_start  = lrck_prev_q & ~lrck_s;

        if (bclk_fall) begin
            lrck_prev_d = lrck_s;
            case (state_q)
                ST_IDLE:  state_d = ST_ARMED;
                ST_ARMED: begin
                    if (left_start) begin
                        state_d = ST_RUN;
                        load    = 1'b1;
                    end
                end
                ST_RUN:   load = left_start;
                default:  state_d = ST_IDLE;
            endcase

            // Slot 0 is the bit period in which LRCK changed; data follows one BCLK later.
            if (state_q == ST_RUN || load) begin
                if (lrck_edge) begin
                    slot_d = '0;
                    chan_d = lrck_s;
                end else if (slot_q != SLOT_MAX) begin
                    slot_d = slot_q + 1'b1;
                end
            end
        end

        half_sel      = chan_d ? frame_q[SAMPLE_W-1:0] : frame_q[FRAME_W-1:SAMPLE_W];
        half_shift    = half_sel << (slot_d - 1'b1);
        slot_has_data = (slot_d != '0) && (slot_d <= SLOT_LAST_DATA);

        if (bclk_fall) begin
            dacdat_d = (state_d == ST_RUN) && slot_has_data && half_shift[SAMPLE_W-1];
        end

        if (load) begin
            if (buf_full_q) begin
                frame_d    = buf_q;
                buf_full_d = 1'b0;
                frame_done = 1'b1;
            end else begin
                underrun = 1'b1;
`ifdef DAC_HOLD_LAST_EN
                frame_d  = frame_q;
`else
                frame_d  = '0;
`endif
            end
        end

        // A word accepted alongside an empty-buffer load waits for the next frame.
        accept = s_if.sample_valid & ready_q;
        if (accept) begin
            buf_d      = s_if.sample_in;
            buf_full_d = 1'b1;
        end
        ready_d = ~buf_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            bclk_dly_q  <= 1'b0;
            state_q     <= ST_IDLE;
            lrck_prev_q <= 1'b0;
            chan_q      <= 1'b0;
            slot_q      <= '0;
            frame_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            ready_q     <= 1'b0;
            dacdat_q    <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            bclk_dly_q  <= bclk_dly_d;
            state_q     <= state_d;
            lrck_prev_q <= lrck_prev_d;
            chan_q      <= chan_d;
            slot_q      <= slot_d;
            frame_q     <= frame_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            ready_q     <= ready_d;
            dacdat_q    <= dacdat_d;
        end
    end

    assign AUD_DACDAT        = dacdat_q;
    assign s_if.sample_ready = ready_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: emulated codec clocks, producer driver, frame-level reference model.
module tb_audio_dac_serializer;
  localparam int SW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       aud_bclk, aud_daclrck, aud_dacdat, frame_done, underrun;
  logic [1:0] dbg_state;

  audio_dac_serializer_if #(.SAMPLE_W(SW)) dac_if ();

  audio_dac_serializer #(.SAMPLE_W(SW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .AUD_BCLK    (aud_bclk),
    .AUD_DACLRCK (aud_daclrck),
    .s_if        (dac_if),
    .AUD_DACDAT  (aud_dacdat),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #2_500_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  int tests_run = 0;
  int tests_failed = 0;

  // codec emulation: 16 clk per BCLK, 64 BCLK per frame; cyc is the pin phase last driven
  int cyc;

  // reference model: frame-level view of the buffer and the transmitted word
  bit          m_seen, m_prev, m_buf_full, ready_exp;
  logic [31:0] m_buf, m_cur;
  logic [31:0] exp_q[$];
  int          fd_model, ur_model, fd_seen, ur_seen;

  // capture of the serial line
  logic [31:0] cap, ch_word;
  bit          ch_run, skip_ch;

  // producer
  logic [31:0] prod_q[$];
  int          gap;
  bit          rand_gaps, pend, pend_inj, inj_armed;
  logic [31:0] inj_w;

  function automatic int slot_of(int c);
    return (c / 16) % 64;
  endfunction

  function automatic logic [31:0] chunk(logic [15:0] h);
    return {1'b0, h, 15'b0};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_prev = 0; m_buf_full = 0; m_buf = '0; m_cur = '0;
    exp_q.delete();
    ch_run = 0;
    pend = 0;
  endtask

  // one BCLK falling edge as seen by the serializer, with LRCK level lr
  task automatic model_fall(bit lr);
    if (!m_seen) begin
      m_seen = 1;
      m_prev = lr;
    end else begin
      if (m_prev && !lr) begin
        if (m_buf_full) begin
          m_cur = m_buf;
          m_buf_full = 0;
          fd_model++;
        end else begin
          ur_model++;
`ifndef DAC_HOLD_LAST_EN
          m_cur = '0;
`endif
        end
        exp_q.push_back(m_cur);
      end
      m_prev = lr;
    end
  endtask

  task automatic drive_pins();
    aud_bclk    = (cyc % 16) >= 8;
    aud_daclrck = slot_of(cyc) >= 32;
  endtask

  task automatic drive_producer();
    bit inj_now;
    inj_now = 0;
    if (inj_armed && (cyc % 16) == 2 && slot_of(cyc) == 0) begin
      dac_if.sample_valid = 1'b1;
      dac_if.sample_in    = inj_w;
      inj_now   = 1;
      inj_armed = 0;
    end else if (prod_q.size() > 0 && gap == 0) begin
      dac_if.sample_valid = 1'b1;
      dac_if.sample_in    = prod_q[0];
    end else begin
      dac_if.sample_valid = 1'b0;
      dac_if.sample_in    = $urandom();
      if (gap > 0) gap--;
    end
    pend     = dac_if.sample_valid && dac_if.sample_ready;
    pend_inj = inj_now;
  endtask

  task automatic capture();
    int  sl;
    int  s;
    bit  left;
    sl   = slot_of(cyc);
    s    = sl % 32;
    left = sl < 32;
    if (s == 0) begin
      cap = '0;
      if (left) begin
        if (exp_q.size() > 0) begin
          ch_word = exp_q.pop_front();
          ch_run  = 1;
        end else begin
          ch_run = 0;
        end
      end
    end
    cap = {cap[30:0], aud_dacdat};
    if (s == 31) begin
      if (!skip_ch)
        check(left ? "left_chunk" : "right_chunk", cap,
              ch_run ? chunk(left ? ch_word[31:16] : ch_word[15:0]) : 32'h0);
      skip_ch = 0;
    end
  endtask

  task automatic tick();
    bit lr, is_load;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if ((cyc % 16) == 2) model_fall(slot_of(cyc) >= 32);
      if (pend) begin
        m_buf      = dac_if.sample_in;
        m_buf_full = 1;
        if (!pend_inj) begin
          void'(prod_q.pop_front());
          if (rand_gaps) gap = $urandom_range(0, 600);
        end
      end
    end
    ready_exp = !rst && !m_buf_full;
    pend = 0;
    @(negedge clk);
    lr      = slot_of(cyc) >= 32;
    is_load = !rst && (cyc % 16) == 1 && m_seen && m_prev && !lr;
    check("frame_done", frame_done, is_load && m_buf_full);
    check("underrun", underrun, is_load && !m_buf_full);
    check("sample_ready", dac_if.sample_ready, ready_exp);
    if (frame_done === 1'b1) fd_seen++;
    if (underrun === 1'b1) ur_seen++;
    if ((cyc % 16) == 12) capture();
    cyc++;
    drive_pins();
    drive_producer();
  endtask

  task automatic run_ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // advance until the pins just driven are at slot b (any slot if b < 0), phase p
  task automatic run_to(int b, int p);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < 2100) begin
      tick();
      n++;
      hit = ((cyc % 16) == p) && (b < 0 || slot_of(cyc) == b);
    end
    check("run_to_reach", hit, 1);
  endtask

  initial begin
    rst = 1'b1;
    cyc = 0;
    gap = 0;
    rand_gaps = 0;
    inj_armed = 0;
    skip_ch = 0;
    fd_model = 0; ur_model = 0; fd_seen = 0; ur_seen = 0;
    cap = '0; ch_word = '0;
    model_reset();
    drive_pins();
    dac_if.sample_valid = 1'b0;
    dac_if.sample_in    = '0;

    // reset state, LRCK already low when reset releases
    run_ticks(3);
    check("reset_dacdat", aud_dacdat, 0);
    check("reset_ready", dac_if.sample_ready, 0);
    check("reset_state", dbg_state, 0);
    run_to(0, 10);
    rst = 1'b0;

    // pre-load before the first genuine LRCK fall
    prod_q.push_back(32'hA5A53C3C);
    run_ticks(1024);
    check("preload_frame_done_count", fd_seen, 1);

    // back-to-back streaming, then one word followed by starvation
    prod_q.push_back(32'h80007FFF);
    prod_q.push_back(32'h0001FFFF);
    prod_q.push_back(32'h12345678);
    run_ticks(4 * 1024);
    check("starve_underrun_count", ur_seen, 1);

    // word offered exactly in the load cycle of an empty buffer
    inj_w = 32'hCAFE0001;
    inj_armed = 1;
    run_ticks(3 * 1024);
    check("inject_underrun_count", ur_seen, 3);

    // randomized words with random producer idle gaps
    rand_gaps = 1;
    for (int i = 0; i < 8; i++) prod_q.push_back($urandom());
    begin
      int n;
      n = 0;
      while (prod_q.size() > 0 && n < 20000) begin
        tick();
        n++;
      end
    end
    check("random_drain", prod_q.size(), 0);
    rand_gaps = 0;
    gap = 0;
    run_ticks(2 * 1024);

    // reset in the middle of a left channel (slot 8)
    prod_q.push_back(32'hFFFF5555);
    for (int k = 0; k < 4 && m_cur != 32'hFFFF5555; k++) run_to(0, 3);
    run_to(8, 12);
    check("pre_reset_dacdat", aud_dacdat, 1);
    rst = 1'b1;
    #1;
    check("midreset_dacdat", aud_dacdat, 0);
    check("midreset_ready", dac_if.sample_ready, 0);
    check("midreset_frame_done", frame_done, 0);
    check("midreset_underrun", underrun, 0);
    skip_ch = 1;
    run_ticks(40);
    run_to(-1, 10);
    rst = 1'b0;
    prod_q.push_back(32'h5A5A0F0F);
    run_ticks(3 * 1024 + 200);

    check("frame_done_total", fd_seen, fd_model);
    check("underrun_total", ur_seen, ur_model);
    check("producer_empty", prod_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
